// File: rtl/kgp_rf_pkg.sv
// Shared widths, the hardwired-zero register index and the write-back queue entry type.
package kgp_rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Write-back push handshake, drain control and the two read ports of reg_file_wb.
interface reg_file_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              drain_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_hazard1;
    logic              rd_hazard2;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output wr_valid, wr_addr, wr_data, drain_en, rd_addr1, rd_addr2,
        input  wr_ready, rd_data1, rd_data2, rd_hazard1, rd_hazard2, q_count
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, drain_en, rd_addr1, rd_addr2,
        output wr_ready, rd_data1, rd_data2, rd_hazard1, rd_hazard2, q_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Negedge-clocked write-back queue; entries are exposed oldest-first so match logic
// can pick the newest hit by scanning upward.
module wb_fifo
    import kgp_rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  wb_entry_t             push_ent,
    output logic                  full,
    output logic                  empty,
    output logic                  pop_ok,
    output logic [CNT_W-1:0]      count,
    output logic [DEPTH-1:0]      age_vld,
    output wb_entry_t [DEPTH-1:0] age_ent
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // Full blocks a push even when a pop lands on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (pop_ok)
            head_d = head_q + 1'b1;
        if (push_ok) begin
            mem_d[tail_q] = push_ent;
            tail_d        = tail_q + 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_ent[k] = mem_q[head_q + PTR_W'(k)];
            age_vld[k] = (CNT_W'(k) < count_q);
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// KGP-RISC register file fronted by a write-back staging queue.
// Define RF_BYPASS_EN to forward pending queue data to the read ports instead of flagging hazards.
module reg_file_wb
    import kgp_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = 4
) (
    input logic          clk,
    input logic          rst,
    reg_file_wb_if.slave bus
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int CNT_W = cnt_width(DEPTH);

    wb_entry_t             push_ent;
    wb_entry_t [DEPTH-1:0] age_ent;
    logic      [DEPTH-1:0] age_vld;
    logic                  full, empty, pop_ok, push;
    logic      [CNT_W-1:0] count;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    assign push_ent.addr = bus.wr_addr;
    assign push_ent.data = bus.wr_data;
    // r0 writes complete the handshake but never occupy a slot.
    assign push         = bus.wr_valid && (bus.wr_addr != REG_ZERO);
    assign bus.wr_ready = !full;
    assign bus.q_count  = count;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (bus.drain_en),
        .push_ent (push_ent),
        .full     (full),
        .empty    (empty),
        .pop_ok   (pop_ok),
        .count    (count),
        .age_vld  (age_vld),
        .age_ent  (age_ent)
    );

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        logic we;
        assign we = pop_ok && (age_ent[0].addr == ADDR_W'(r));

        always_comb begin
            regs_d[r] = regs_q[r];
            if (we)
                regs_d[r] = age_ent[0].data;
        end

        always_ff @(negedge clk or negedge rst) begin
            if (!rst)
                regs_q[r] <= '0;
            else
                regs_q[r] <= regs_d[r];
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_hz   [2];

    assign rd_addr[0]     = bus.rd_addr1;
    assign rd_addr[1]     = bus.rd_addr2;
    assign bus.rd_data1   = rd_data[0];
    assign bus.rd_data2   = rd_data[1];
    assign bus.rd_hazard1 = rd_hz[0];
    assign bus.rd_hazard2 = rd_hz[1];

    // Oldest-to-newest scan: the last hit is the newest pending write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_hz[p]   = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (age_vld[k] && (age_ent[k].addr == rd_addr[p])) begin
`ifdef RF_BYPASS_EN
                    rd_data[p] = age_ent[k].data;
`else
                    rd_hz[p]   = 1'b1;
`endif
                end
            end
            if (rd_addr[p] == REG_ZERO) begin
                rd_data[p] = '0;
                rd_hz[p]   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed and random stimulus for reg_file_wb, checked against a queue-based reference model.
module tb_reg_file_wb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ent_t              q [$];
    logic [DATA_W-1:0] ref_regs [32];

    reg_file_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    reg_file_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == a) return q[i].d;
`endif
        return ref_regs[a];
    endfunction

    function automatic logic exp_hz(input logic [ADDR_W-1:0] a);
`ifndef RF_BYPASS_EN
        if (a != 0)
            foreach (q[i])
                if (q[i].a == a) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".q_count"},  DATA_W'(bus.q_count),   DATA_W'(q.size()));
        chk({tag, ".wr_ready"}, DATA_W'(bus.wr_ready),  DATA_W'(q.size() < DEPTH));
        chk({tag, ".rd_data1"}, bus.rd_data1,           exp_rd(bus.rd_addr1));
        chk({tag, ".rd_data2"}, bus.rd_data2,           exp_rd(bus.rd_addr2));
        chk({tag, ".rd_hz1"},   DATA_W'(bus.rd_hazard1), DATA_W'(exp_hz(bus.rd_addr1)));
        chk({tag, ".rd_hz2"},   DATA_W'(bus.rd_hazard2), DATA_W'(exp_hz(bus.rd_addr2)));
    endtask

    // One clock: drive on posedge, model the negedge update, check just after it.
    task automatic step(input string tag, input bit v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit de,
                        input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        bit   acc, popd;
        ent_t e;
        @(posedge clk);
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.drain_en = de;
        bus.rd_addr1 = r1;
        bus.rd_addr2 = r2;
        @(negedge clk);
        popd = de && (q.size() > 0);
        acc  = v && (q.size() < DEPTH);
        if (popd) begin
            e = q.pop_front();
            ref_regs[e.a] = e.d;
        end
        if (acc && a != 0) begin
            e.a = a;
            e.d = d;
            q.push_back(e);
        end
        #1 check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.drain_en = 1'b0;
    endtask

    task automatic sweep(input string tag);
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr1 = ADDR_W'(i);
            bus.rd_addr2 = ADDR_W'(31 - i);
            #1;
            chk({tag, ".rd1"}, bus.rd_data1, exp_rd(ADDR_W'(i)));
            chk({tag, ".rd2"}, bus.rd_data2, exp_rd(ADDR_W'(31 - i)));
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (ref_regs[i]) ref_regs[i] = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.drain_en = 1'b0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;

        // Reset state
        #2;
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr1 = ADDR_W'(i);
            bus.rd_addr2 = ADDR_W'(31 - i);
            #1;
            chk("rst.rd1", bus.rd_data1, '0);
            chk("rst.rd2", bus.rd_data2, '0);
        end
        chk("rst.wr_ready", DATA_W'(bus.wr_ready), 1);
        chk("rst.q_count",  DATA_W'(bus.q_count), 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Basic write with minimum latency
        step("basic.push", 1, 5, 32'hDEADBEEF, 1, 5, 0);
        chk("basic.cnt1", DATA_W'(bus.q_count), 1);
        step("basic.drain", 0, 0, 0, 1, 5, 0);
        chk("basic.r5", bus.rd_data1, 32'hDEADBEEF);
        chk("basic.cnt0", DATA_W'(bus.q_count), 0);

        // Fill the queue, refuse a 5th push, including one with a simultaneous pop
        for (int i = 0; i < 4; i++)
            step("fill", 1, ADDR_W'(10 + i), 32'h100 + i, 0, ADDR_W'(10 + i), 10);
        chk("fill.ready", DATA_W'(bus.wr_ready), 0);
        chk("fill.cnt", DATA_W'(bus.q_count), 4);
        step("fill.5th", 1, 20, 32'hBAD0, 0, 20, 10);
        step("fill.passthru", 1, 21, 32'hBAD1, 1, 21, 10);
        chk("fill.r10", bus.rd_data2, 32'h100);
        chk("fill.cnt3", DATA_W'(bus.q_count), 3);
        for (int i = 0; i < 3; i++)
            step("drain", 0, 0, 0, 1, ADDR_W'(11 + i), 21);
        chk("drain.r21", bus.rd_data2, 0);
        chk("drain.cnt", DATA_W'(bus.q_count), 0);

        // Same-address ordering
        step("same.a", 1, 7, 1, 0, 7, 7);
        step("same.b", 1, 7, 2, 0, 7, 7);
`ifdef RF_BYPASS_EN
        chk("same.data", bus.rd_data1, 2);
        chk("same.hz",   DATA_W'(bus.rd_hazard1), 0);
`else
        chk("same.data", bus.rd_data1, 0);
        chk("same.hz",   DATA_W'(bus.rd_hazard1), 1);
`endif
        step("same.d1", 0, 0, 0, 1, 7, 7);
        step("same.d2", 0, 0, 0, 1, 7, 7);
        chk("same.final", bus.rd_data1, 2);
        chk("same.hz0",   DATA_W'(bus.rd_hazard1), 0);

        // r0 writes are swallowed
        step("zero", 1, 0, 32'hFFFF, 0, 0, 0);
        chk("zero.cnt", DATA_W'(bus.q_count), 0);
        chk("zero.r0",  bus.rd_data1, 0);

        // Asynchronous reset with pending entries
        step("mid.p0", 1, 9,  32'hA9, 0, 9, 10);
        step("mid.p1", 1, 10, 32'hAA, 0, 9, 10);
        step("mid.p2", 1, 11, 32'hAB, 0, 9, 10);
        @(posedge clk);
        idle_inputs();
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("mid.cnt",   DATA_W'(bus.q_count), 0);
        chk("mid.ready", DATA_W'(bus.wr_ready), 1);
        chk("mid.r10",   bus.rd_data2, 0);
        chk("mid.r5",    dut.regs_q[5], 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++)
            step("mid.after", 0, 0, 0, 1, ADDR_W'(9 + i), 5);
        sweep("mid.sweep");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] a, r1, r2;
            bit de;
            a  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'($urandom_range(0, 7));
            r1 = ADDR_W'($urandom_range(0, 7));
            r2 = ADDR_W'($urandom_range(0, 31));
            de = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step("rand", bit'($urandom_range(0, 1)), a, $urandom, de, r1, r2);
        end
        for (int i = 0; i < DEPTH; i++)
            step("rand.flush", 0, 0, 0, 1, 1, 2);
        sweep("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
